// File: rtl/seven_seg_if.sv
// Register-side controls and pin-side outputs of the multiplexed 7-segment driver.
// The bus/register logic holds the master modport and the driver holds the slave modport.
interface seven_seg_if #(
    parameter int NUM_DIGITS = 4,
    parameter int BRIGHT_W   = 4
);
    logic [NUM_DIGITS*5-1:0] digit_data;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    load;
    logic                    blank_lz;
    logic [BRIGHT_W-1:0]     brightness;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   anode;
    logic                    frame_start;
    logic                    upd_pending;

    modport master (
        output digit_data,
        output digit_en,
        output load,
        output blank_lz,
        output brightness,
        input  seg,
        input  dp,
        input  anode,
        input  frame_start,
        input  upd_pending
    );

    modport slave (
        input  digit_data,
        input  digit_en,
        input  load,
        input  blank_lz,
        input  brightness,
        output seg,
        output dp,
        output anode,
        output frame_start,
        output upd_pending
    );
endinterface

// File: rtl/seven_seg_mux.sv
// Multiplexed N-digit 7-segment driver: prescaled scan, per-digit PWM and enable,
// leading-zero suppression and a double buffer that only swaps at frame boundaries.
module seven_seg_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 1000,
    parameter int BRIGHT_W       = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input logic        clk,
    input logic        rst_n,
    seven_seg_if.slave bus
);
    localparam int PRESC_W = $clog2(CLK_DIV);
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int DATA_W  = NUM_DIGITS * 5;

    localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_INV    = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_INV     = {NUM_DIGITS{AN_ACTIVE_LOW}};

    typedef struct packed {
        logic [DATA_W-1:0]     data;
        logic [NUM_DIGITS-1:0] en;
        logic                  lz;
    } disp_cfg_t;

    // Scan position
    logic [PRESC_W-1:0]  presc;
    logic [BRIGHT_W-1:0] phase;
    logic [IDX_W-1:0]    idx;
    logic [BRIGHT_W-1:0] bright_q;

    // Double-buffered display contents
    disp_cfg_t act;
    disp_cfg_t pend;
    disp_cfg_t in_cfg;
    logic      pending;

    logic                tick;
    logic                phase_wrap;
    logic                frame_end;
    logic                slot_first;
    logic [BRIGHT_W-1:0] eff_bright;

    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  lz_run;
    logic [4:0]            cur;
    logic                  cur_en;
    logic                  cur_blank;
    logic [NUM_DIGITS-1:0] an_hit;
    logic                  an_on;
    logic [NUM_DIGITS-1:0] an_lit;
    logic [6:0]            seg_lit;
    logic                  dp_lit;

    // Returns the lit segments {g..a} as active-high; the table is kept in the
    // familiar active-low form and inverted once.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] al;
        case (v)
            4'h0: al = 7'b1000000;
            4'h1: al = 7'b1111001;
            4'h2: al = 7'b0100100;
            4'h3: al = 7'b0110000;
            4'h4: al = 7'b0011001;
            4'h5: al = 7'b0010010;
            4'h6: al = 7'b0000010;
            4'h7: al = 7'b1111000;
            4'h8: al = 7'b0000000;
            4'h9: al = 7'b0010000;
            4'hA: al = 7'b0001000;
            4'hB: al = 7'b0000011;
            4'hC: al = 7'b1000110;
            4'hD: al = 7'b0100001;
            4'hE: al = 7'b0000110;
            default: al = 7'b0001110;
        endcase
        return ~al;
    endfunction

    assign in_cfg     = {bus.digit_data, bus.digit_en, bus.blank_lz};
    assign tick       = (presc == PRESC_LAST);
    assign phase_wrap = tick && (phase == '1);
    assign frame_end  = phase_wrap && (idx == IDX_LAST);
    assign slot_first = (presc == '0) && (phase == '0);

    // The first cycle of a slot already uses the live brightness; the rest of the
    // slot uses the value captured on that cycle.
    assign eff_bright = slot_first ? bus.brightness : bright_q;

    assign bus.upd_pending = pending;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        lz_blank  = '0;
        lz_run    = act.lz;
        cur       = '0;
        cur_en    = 1'b0;
        cur_blank = 1'b0;
        an_hit    = '0;

        // Blanking propagates downward from the top digit while digits read as zero;
        // a disabled digit reads as zero. Digit 0 is never part of the chain.
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            lz_run      = lz_run && ((act.data[5*k +: 4] == 4'h0) || !act.en[k]);
            lz_blank[k] = lz_run;
        end

        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur       = act.data[5*k +: 5];
                cur_en    = act.en[k];
                cur_blank = lz_blank[k];
                an_hit[k] = 1'b1;
            end
        end

        an_on   = cur_en && (phase < eff_bright);
        an_lit  = an_on ? an_hit : '0;
        seg_lit = (an_on && !cur_blank) ? glyph(cur[3:0]) : 7'h00;
        dp_lit  = an_on && cur[4];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc           <= '0;
            phase           <= '0;
            idx             <= '0;
            bright_q        <= '0;
            // NOTE: the active/pending buffers are reset too, because a display
            // that lights stale garbage after reset is a visible fault.
            act             <= '0;
            pend            <= '0;
            pending         <= 1'b0;
            bus.seg         <= SEG_INV;
            bus.dp          <= SEG_ACTIVE_LOW;
            bus.anode       <= AN_INV;
            bus.frame_start <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                phase <= phase + 1'b1;
            end
            if (phase_wrap) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            if (slot_first) begin
                bright_q <= bus.brightness;
            end

            // A load on the boundary cycle itself bypasses the pending buffer.
            if (frame_end) begin
                if (bus.load) begin
                    act <= in_cfg;
                end else if (pending) begin
                    act <= pend;
                end
                pending <= 1'b0;
            end else if (bus.load) begin
                pend    <= in_cfg;
                pending <= 1'b1;
            end

            bus.seg         <= seg_lit ^ SEG_INV;
            bus.dp          <= dp_lit ^ SEG_ACTIVE_LOW;
            bus.anode       <= an_lit ^ AN_INV;
            bus.frame_start <= slot_first && (idx == '0);
        end
    end
endmodule

// File: tb/tb_seven_seg_mux.sv
// Directed bench for seven_seg_mux: per-frame expectations are queued when data is
// loaded and popped as each observed frame (4 slots of 16 clocks) completes.
module tb_seven_seg_mux;
    localparam int NUM_DIGITS = 4;
    localparam int CLK_DIV    = 4;
    localparam int BRIGHT_W   = 2;

    localparam logic [19:0] BASIC = {5'h0A, 5'h11, 5'h00, 5'h0F};
    localparam logic [19:0] DAT_X = {5'h02, 5'h0B, 5'h0C, 5'h0D};
    localparam logic [19:0] DAT_Y = {5'h06, 5'h17, 5'h08, 5'h09};
    localparam logic [19:0] DAT_Z = {5'h0E, 5'h03, 5'h04, 5'h01};
    localparam logic [19:0] LZ_5  = {5'h00, 5'h10, 5'h00, 5'h05};
    localparam logic [19:0] LZ_0  = {5'h00, 5'h00, 5'h00, 5'h00};
    localparam logic [19:0] LZ_3  = {5'h00, 5'h03, 5'h00, 5'h00};
    localparam logic [19:0] LZ_D  = {5'h07, 5'h00, 5'h02, 5'h00};
    localparam logic [19:0] EN_D  = {5'h08, 5'h09, 5'h0A, 5'h0B};

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         on_cnt;
    } slot_exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    slot_exp_t exp_q[$];

    seven_seg_if #(.NUM_DIGITS(NUM_DIGITS), .BRIGHT_W(BRIGHT_W)) bus ();

    seven_seg_mux #(
        .NUM_DIGITS    (NUM_DIGITS),
        .CLK_DIV       (CLK_DIV),
        .BRIGHT_W      (BRIGHT_W),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Expected view of one frame: digit k is lit for bright*CLK_DIV clocks of its slot.
    task automatic push_frame(input logic [19:0] data, input logic [3:0] en, input logic lz,
                              input logic [3:0][1:0] bv);
        slot_exp_t e;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            logic [3:0] nib;
            logic       blank;
            int         on;
            nib   = data[5*k +: 4];
            blank = lz && (k != 0);
            for (int j = k; j < NUM_DIGITS; j++) begin
                if (data[5*j +: 4] != 4'h0 && en[j]) blank = 1'b0;
            end
            on       = en[k] ? int'(bv[k]) * CLK_DIV : 0;
            e.on_cnt = on;
            e.an     = (on != 0) ? ~(4'b0001 << k) : 4'hF;
            e.seg    = (on == 0 || blank) ? 7'h7F : GLYPH[nib];
            e.dp     = (on == 0) ? 1'b1 : ~data[5*k+4];
            exp_q.push_back(e);
        end
    endtask

    // Starts on the negedge of a frame_start cycle and watches 64 output cycles.
    task automatic observe_frame(input string name);
        logic [3:0] an_o  [4];
        logic [6:0] seg_o [4];
        logic       dp_o  [4];
        int         cnt   [4];
        int         viol;
        slot_exp_t  e;
        viol = 0;
        for (int s = 0; s < 4; s++) begin
            an_o[s] = 4'hF; seg_o[s] = 7'h7F; dp_o[s] = 1'b1; cnt[s] = 0;
        end
        for (int i = 0; i < 64; i++) begin
            int s;
            s = i / 16;
            if (i > 0) @(negedge clk);
            if (i > 0 && bus.frame_start !== 1'b0) viol++;
            if (bus.anode !== 4'hF) begin
                if (cnt[s] > 0 && (bus.anode !== an_o[s] || bus.seg !== seg_o[s] || bus.dp !== dp_o[s]))
                    viol++;
                cnt[s]++;
                an_o[s]  = bus.anode;
                seg_o[s] = bus.seg;
                dp_o[s]  = bus.dp;
            end else if (bus.seg !== 7'h7F || bus.dp !== 1'b1) begin
                viol++;
            end
        end
        check($sformatf("%s_clean", name), viol, 0);
        for (int s = 0; s < 4; s++) begin
            e = exp_q.pop_front();
            check($sformatf("%s_s%0d_an_seg_dp", name, s),
                  {20'h0, an_o[s], seg_o[s], dp_o[s]}, {20'h0, e.an, e.seg, e.dp});
            check($sformatf("%s_s%0d_on_clocks", name, s), cnt[s], e.on_cnt);
        end
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.frame_start !== 1'b1 && n < 200);
        check("frame_start_seen", {31'h0, bus.frame_start}, 1);
    endtask

    // NOTE: inputs change on the falling edge with blocking assignments, so the DUT's
    // rising edge always samples settled values.
    task automatic load_pulse(input logic [19:0] data, input logic [3:0] en, input logic lz);
        bus.digit_data = data;
        bus.digit_en   = en;
        bus.blank_lz   = lz;
        bus.load       = 1'b1;
        @(negedge clk);
        bus.load       = 1'b0;
    endtask

    // Loads mid-frame, then checks the whole following frame.
    task automatic scan_case(input string name, input logic [19:0] data, input logic [3:0] en,
                             input logic lz, input logic [1:0] br);
        int n;
        wait_fs(n);
        repeat (8) @(negedge clk);
        bus.brightness = br;
        load_pulse(data, en, lz);
        check({name, "_upd_set"}, {31'h0, bus.upd_pending}, 1);
        wait_fs(n);
        check({name, "_upd_clr"}, {31'h0, bus.upd_pending}, 0);
        push_frame(data, en, lz, {4{br}});
        observe_frame(name);
    endtask

    initial begin
        int n;
        total = 0;
        passed = 0;
        rst_n = 1'b0;
        bus.digit_data = '0;
        bus.digit_en   = '0;
        bus.load       = 1'b0;
        bus.blank_lz   = 1'b0;
        bus.brightness = 2'd3;

        repeat (3) @(negedge clk);
        check("rst_anode", {28'h0, bus.anode}, 32'hF);
        check("rst_seg", {25'h0, bus.seg}, 32'h7F);
        check("rst_dp", {31'h0, bus.dp}, 1);
        check("rst_frame_start", {31'h0, bus.frame_start}, 0);
        check("rst_upd", {31'h0, bus.upd_pending}, 0);
        rst_n = 1'b1;

        // Idle after reset: dark display, frame_start every 64 clocks
        wait_fs(n);
        wait_fs(n);
        check("fs_period", n, 64);
        check("idle_upd", {31'h0, bus.upd_pending}, 0);
        push_frame(20'h0, 4'h0, 1'b0, {4{2'd3}});
        observe_frame("idle");

        scan_case("basic", BASIC, 4'hF, 1'b0, 2'd3);

        // Tear-free update: two loads mid-frame, old glyphs hold, last load wins
        wait_fs(n);
        push_frame(BASIC, 4'hF, 1'b0, {4{2'd3}});
        fork
            observe_frame("tear_old");
            begin
                repeat (10) @(negedge clk);
                load_pulse(DAT_X, 4'hF, 1'b0);
                check("tear_upd_set", {31'h0, bus.upd_pending}, 1);
                repeat (18) @(negedge clk);
                load_pulse(DAT_Y, 4'hF, 1'b0);
                repeat (28) @(negedge clk);
                check("tear_upd_hold", {31'h0, bus.upd_pending}, 1);
            end
        join
        wait_fs(n);
        check("tear_upd_clr", {31'h0, bus.upd_pending}, 0);
        push_frame(DAT_Y, 4'hF, 1'b0, {4{2'd3}});
        observe_frame("tear_new");

        // Load exactly on the boundary cycle goes straight to the active buffer
        wait_fs(n);
        repeat (62) @(negedge clk);
        load_pulse(DAT_Z, 4'hF, 1'b0);
        check("bnd_upd_stays_0", {31'h0, bus.upd_pending}, 0);
        wait_fs(n);
        check("bnd_fs_next", n, 1);
        push_frame(DAT_Z, 4'hF, 1'b0, {4{2'd3}});
        observe_frame("bnd_load");

        // One cycle later it waits a whole frame
        wait_fs(n);
        repeat (63) @(negedge clk);
        load_pulse(LZ_5, 4'hF, 1'b1);
        check("late_upd_set", {31'h0, bus.upd_pending}, 1);
        check("late_is_fs", {31'h0, bus.frame_start}, 1);
        push_frame(DAT_Z, 4'hF, 1'b0, {4{2'd3}});
        observe_frame("late_old");
        wait_fs(n);
        push_frame(LZ_5, 4'hF, 1'b1, {4{2'd3}});
        observe_frame("lz_0005");

        scan_case("lz_0000", LZ_0, 4'hF, 1'b1, 2'd3);
        scan_case("lz_0300", LZ_3, 4'hF, 1'b1, 2'd3);
        scan_case("lz_disabled", LZ_D, 4'b0111, 1'b1, 2'd3);
        scan_case("en_0101", EN_D, 4'b0101, 1'b0, 2'd3);
        scan_case("bright0", BASIC, 4'hF, 1'b0, 2'd0);
        scan_case("bright1", BASIC, 4'hF, 1'b0, 2'd1);

        // Brightness raised during slot 1 applies from slot 2
        wait_fs(n);
        push_frame(BASIC, 4'hF, 1'b0, {2'd3, 2'd3, 2'd1, 2'd1});
        fork
            observe_frame("bright_mid");
            begin
                repeat (20) @(negedge clk);
                bus.brightness = 2'd3;
            end
        join

        // Reset during digit 2's slot with an update pending
        wait_fs(n);
        repeat (36) @(negedge clk);
        load_pulse(DAT_Z, 4'hF, 1'b0);
        check("mid_rst_upd_before", {31'h0, bus.upd_pending}, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_anode", {28'h0, bus.anode}, 32'hF);
        check("mid_rst_seg", {25'h0, bus.seg}, 32'h7F);
        check("mid_rst_dp", {31'h0, bus.dp}, 1);
        check("mid_rst_upd", {31'h0, bus.upd_pending}, 0);
        check("mid_rst_fs", {31'h0, bus.frame_start}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_fs(n);
        check("post_rst_upd", {31'h0, bus.upd_pending}, 0);
        push_frame(20'h0, 4'h0, 1'b0, {4{2'd3}});
        observe_frame("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/seven_seg_mux.md
Name: seven_seg_mux

Overview:
Parametrised multiplexed 7-segment display driver for N digits. It has an internal refresh prescaler, so it runs directly from the system clock. Features:
- per-digit PWM brightness
- per-digit enable
- optional leading-zero suppression
- tear-free double-buffered updates applied only at frame boundaries

It sits between bus/register logic (e.g. a CPU-visible display port) and the board's segment and anode pins.

Parameters:
NUM_DIGITS, 4, number of digits; must be ≥2.
CLK_DIV, 1000, system clocks per prescaler tick; must be ≥2.
BRIGHT_W, 4, brightness width; each digit slot lasts 2**BRIGHT_W ticks.
SEG_ACTIVE_LOW, 1, 1: a lit segment/dp drives 0; 0: a lit segment/dp drives 1.
AN_ACTIVE_LOW, 1, 1: an asserted anode drives 0; 0: an asserted anode drives 1.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
digit_data  in  NUM_DIGITS*5  digit k at [5k+4:5k]; bit 4 = dp, bits 3:0 = hex value
digit_en  in  NUM_DIGITS  per-digit enable; 0 = digit fully dark
load  in  1  1-cycle strobe that captures digit_data, digit_en and blank_lz
blank_lz  in  1  leading-zero suppression enable
brightness  in  BRIGHT_W  on-time in ticks per digit slot; 0 = dark
seg  out  7  seg[0]=a … seg[6]=g, polarity per SEG_ACTIVE_LOW
dp  out  1  decimal point
anode  out  NUM_DIGITS  anode[k] drives digit k; digit 0 is the rightmost
frame_start  out  1  1-cycle pulse when digit 0's slot begins
upd_pending  out  1  a captured update is waiting for the next frame boundary

Behaviour:
- One clock domain: clk. Reset is synchronous and active-low on rst_n. All state and outputs are registered.
- Reset (rst_n=0 at a clk edge):
  - prescaler, phase and digit index all return to 0;
  - active and pending data regs cleared to 0, enables to 0;
  - upd_pending=0, frame_start=0;
  - seg, dp and anode all at their inactive level.
- Reset mid-frame aborts the scan immediately, with the same values as above.
- Prescaler: counts 0..CLK_DIV-1 and raises tick on CLK_DIV-1.
- Phase: increments on each tick and wraps at 2**BRIGHT_W-1.
- Digit index: advances on a tick where phase wraps. Wrap of the index from NUM_DIGITS-1 to 0 is the frame boundary.
- Timing: slot = 2**BRIGHT_W*CLK_DIV clocks; frame = NUM_DIGITS × slot.
- Brightness: sampled at the start of each slot (phase 0). Input changes mid-slot have no effect until the next slot.
- Anode for the current index is asserted while phase < sampled brightness AND active_en[index]=1. All other anodes are inactive.
  - Max duty = (2**BRIGHT_W-1)/2**BRIGHT_W.
  - Outputs lag internal state by exactly 1 clock.
- Glyphs: hex 0-F, with b and d lower-case. Active-low {g..a} encodings:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
  - Active-high mode is the bitwise inverse.
- Segment output: while the anode is deasserted, seg and dp are driven inactive.
- Leading-zero suppression (active blank_lz=1):
  - digit k is segment-blanked if its nibble is 0 and every digit above k is also blanked or disabled;
  - digit 0 is never LZ-blanked;
  - dp of an LZ-blanked digit is still shown, and the anode still pulses.
  - Disabled digits count as zeros for the LZ chain.
- Update handshake:
  - load=1 copies digit_data, digit_en and blank_lz into pending regs and sets upd_pending.
  - At the next frame boundary, pending is copied to active and upd_pending clears.
  - A second load before the boundary overwrites pending (last write wins).
  - load on the boundary cycle itself writes straight to active; upd_pending stays 0.
  - Active data never changes mid-frame.
- frame_start pulses for 1 clock, aligned with the first output cycle of digit 0's slot. It pulses every frame, regardless of load.

Test Plan:
- Reset and idle: CLK_DIV=4, BRIGHT_W=2, NUM_DIGITS=4, hold rst_n=0 for 3 clocks, release with no load → anode=4'b1111, seg=7'h7F, dp=1 forever; frame_start pulses every 64 clocks.
- Basic scan: load digit_data={0_1010,1_0001,0_0000,0_1111}, digit_en=4'hF, brightness=3 → digit 0 shows F=0001110; digit 1 shows 0=1000000; digit 2 shows 1=1111001 with dp=0; digit 3 shows A=0001000. Each anode is low 12 of every 16 clocks, in order 1110, 1101, 1011, 0111.
- Tear-free update: load in mid-frame → upd_pending=1 and the old glyphs persist until the boundary. On the first frame_start cycle the new glyphs appear and upd_pending=0. A second load before the boundary → only the second data is shown.
- Leading-zero: blank_lz=1 with data 0,0,0,5 (digit3..0) → digits 3-1 show seg 7F with anodes still pulsing; digit 0 shows 5. Data 0,0,0,0 → digit 0 shows 0. Data 0,3,0,0 → digit 3 blanked only.
- Brightness/enable: brightness=0 → all anodes inactive. brightness=1 → 4 of 16 clocks per slot. digit_en=4'b0101 → anodes 1 and 3 are never asserted. A brightness change mid-slot takes effect at the next slot.
- Reset mid-operation: assert rst_n=0 during digit 2's slot with upd_pending=1 → the next clock gives all outputs inactive and upd_pending=0; after release the display stays dark until a new load.
